not1_inertial: RTL and testbench

Clocked tri-state inverter with inertial delay, equivalent to a `notif1` gate with rise, fall and turn-off delays. When the enable is high, `out` drives the inverse of `inp`. When the enable is low, `out` is high-impedance. Any input or enable pulse shorter than the applicable delay is swallowed and never reaches `out`. The block is a leaf cell used where a delayed, glitch-filtered tri-state driver feeds a shared line.

---
 rtl/not1_inertial.sv | 104 ++++++++++
 tb/tb_not1_inertial.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/not1_inertial.sv
// Clocked tri-state inverter (notif1) with inertial rise/fall/turn-off delays.
// Define NOT1_GLITCH_CNT_EN to add the saturating glitch_cnt port and counter.
module not1_inertial #(
  parameter int RISE_DLY = 3,
  parameter int FALL_DLY = 3,
  parameter int OFF_DLY  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inp,
  input  logic             ctrl1,
  output tri               out,
  output logic             out_drv,
  output logic             busy
`ifdef NOT1_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  // One encoding shared by the committed state (never NONE) and the pending value.
  typedef enum logic [1:0] {
    V0    = 2'd0,
    V1    = 2'd1,
    VZ    = 2'd2,
    VNONE = 2'd3
  } val_t;

  val_t             s_q, s_nxt;
  val_t             p_q, p_nxt;
  val_t             tgt;
  logic [CNT_W-1:0] c_q, c_nxt;

  function automatic logic [CNT_W-1:0] dly_of(input val_t v);
    logic [CNT_W-1:0] d;
    case (v)
      V1:      d = CNT_W'(RISE_DLY);
      V0:      d = CNT_W'(FALL_DLY);
      default: d = CNT_W'(OFF_DLY);
    endcase
    return d;
  endfunction

  always_comb begin
    if (!ctrl1)   tgt = VZ;
    else if (inp) tgt = V0;
    else          tgt = V1;
  end

  always_comb begin
    s_nxt = s_q;
    p_nxt = p_q;
    c_nxt = c_q;
    if (tgt == s_q) begin
      p_nxt = VNONE;
      c_nxt = '0;
    end else begin
      if (tgt != p_q) begin
        p_nxt = tgt;
        c_nxt = CNT_W'(1);
      end else if (c_q != '1) begin
        c_nxt = c_q + CNT_W'(1);
      end
      // Commit on the same edge the persistence count reaches the delay, so D=1 is immediate.
      if (c_nxt == dly_of(tgt)) begin
        s_nxt = tgt;
        p_nxt = VNONE;
        c_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= VZ;
      p_q <= VNONE;
      c_q <= '0;
    end else begin
      s_q <= s_nxt;
      p_q <= p_nxt;
      c_q <= c_nxt;
    end
  end

`ifdef NOT1_GLITCH_CNT_EN
  // A pending value is abandoned whenever the target no longer matches it (P never equals S).
  logic rej;
  assign rej = (p_q != VNONE) && (tgt != p_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (rej && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end
`endif

  assign out     = (s_q == VZ) ? 1'bz : (s_q == V1);
  assign out_drv = (s_q != VZ);
  assign busy    = (p_q != VNONE);

endmodule

// File: tb/tb_not1_inertial.sv
// Directed bench for not1_inertial with default delays (rise 3, fall 3, off 2).
// Glitch-count checks are compiled only when NOT1_GLITCH_CNT_EN is defined.
module tb_not1_inertial;

  logic clk;
  logic rst_n;
  logic inp;
  logic ctrl1;
  wire  out;
  logic out_drv;
  logic busy;
`ifdef NOT1_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_tests;
  int n_fail;

  not1_inertial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inp     (inp),
    .ctrl1   (ctrl1),
    .out     (out),
    .out_drv (out_drv),
    .busy    (busy)
`ifdef NOT1_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl1 = 1'b1;
    inp   = 1'b0;
    tick();
    tick();
    n_tests++;
    if (out_drv !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_drv: got %b want 0", out_drv); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_glitch: got %0d want 0", glitch_cnt); end
`endif
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b1 || out_drv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rise_edge1: busy=%b drv=%b want busy=1 drv=0", busy, out_drv);
    end
    tick();
    n_tests++;
    if (out_drv !== 1'b0) begin n_fail++; $display("[TB] FAIL rise_edge2: drv=%b want 0", out_drv); end
    tick();
    n_tests++;
    if (out_drv !== 1'b1 || out !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rise_edge3: drv=%b out=%b busy=%b want 1 1 0", out_drv, out, busy);
    end
  endtask

  task automatic test_glitch();
    inp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1 || out !== 1'b1) begin
        n_fail++; $display("[TB] FAIL glitch_pulse%0d: busy=%b out=%b want 1 1", i, busy, out);
      end
    end
    inp = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || out !== 1'b1 || out_drv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL glitch_end: busy=%b out=%b drv=%b want 0 1 1", busy, out, out_drv);
    end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL glitch_cnt1: got %0d want 1", glitch_cnt); end
`endif
  endtask

  task automatic test_fall();
    inp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (out !== 1'b1) begin n_fail++; $display("[TB] FAIL fall_hold%0d: out=%b want 1", i, out); end
    end
    tick();
    n_tests++;
    if (out !== 1'b0 || out_drv !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fall_commit: out=%b drv=%b busy=%b want 0 1 0", out, out_drv, busy);
    end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL fall_glitch: got %0d want 1", glitch_cnt); end
`endif
  endtask

  task automatic test_off();
    ctrl1 = 1'b0;
    tick();
    n_tests++;
    if (out_drv !== 1'b1 || out !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL off_edge1: drv=%b out=%b busy=%b want 1 0 1", out_drv, out, busy);
    end
    tick();
    n_tests++;
    if (out_drv !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL off_edge2: drv=%b busy=%b want 0 0", out_drv, busy);
    end
    // Re-enable with inp=1 so the target is 0; fall delay applies from Z.
    ctrl1 = 1'b1;
    inp   = 1'b1;
    tick();
    tick();
    n_tests++;
    if (out_drv !== 1'b0) begin n_fail++; $display("[TB] FAIL reen_edge2: drv=%b want 0", out_drv); end
    tick();
    n_tests++;
    if (out_drv !== 1'b1 || out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reen_edge3: drv=%b out=%b want 1 0", out_drv, out);
    end
    ctrl1 = 1'b0;
    tick();
    ctrl1 = 1'b1;
    tick();
    n_tests++;
    if (out_drv !== 1'b1 || out !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL off_pulse: drv=%b out=%b busy=%b want 1 0 0", out_drv, out, busy);
    end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd2) begin n_fail++; $display("[TB] FAIL off_pulse_glitch: got %0d want 2", glitch_cnt); end
`endif
  endtask

  task automatic test_switch();
    inp = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (out !== 1'b1 || out_drv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL switch_setup: out=%b drv=%b want 1 1", out, out_drv);
    end
    ctrl1 = 1'b0;
    tick();
    ctrl1 = 1'b1;
    inp   = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b1 || out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL switch_edge1: busy=%b out=%b want 1 1", busy, out);
    end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd3) begin n_fail++; $display("[TB] FAIL switch_glitch: got %0d want 3", glitch_cnt); end
`endif
    tick();
    n_tests++;
    if (out !== 1'b1) begin n_fail++; $display("[TB] FAIL switch_edge2: out=%b want 1", out); end
    tick();
    n_tests++;
    if (out !== 1'b0 || out_drv !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL switch_edge3: out=%b drv=%b busy=%b want 0 1 0", out, out_drv, busy);
    end
  endtask

  task automatic test_async_reset();
    inp = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b1 || out_drv !== 1'b1) begin
      n_fail++; $display("[TB] FAIL areset_pre: busy=%b drv=%b want 1 1", busy, out_drv);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || out_drv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_now: busy=%b drv=%b want 0 0", busy, out_drv);
    end
`ifdef NOT1_GLITCH_CNT_EN
    n_tests++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL areset_glitch: got %0d want 0", glitch_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    inp     = 1'b0;
    ctrl1   = 1'b0;
    test_reset();
    test_glitch();
    test_fall();
    test_off();
    test_switch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
